// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative shift-add MUL
// and restoring DIV, one bit per cycle, with registered results and flags.
//
// state | meaning
// IDLE  | waiting for Start; single-cycle ops complete directly from here
// RUN   | MUL/DIV iterating, one bit per cycle, WIDTH cycles total
module alu_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [3:0]       Sel,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Resultado,
    output logic [WIDTH-1:0] ResultadoHi,
    output logic             ZF,
    output logic             NF,
    output logic             CF,
    output logic             OVF,
    output logic             DZ
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] SEL_AND  = 4'd0;
    localparam logic [3:0] SEL_OR   = 4'd1;
    localparam logic [3:0] SEL_ADD  = 4'd2;
    localparam logic [3:0] SEL_MUL  = 4'd3;
    localparam logic [3:0] SEL_DIV  = 4'd4;
    localparam logic [3:0] SEL_XOR  = 4'd5;
    localparam logic [3:0] SEL_SUB  = 4'd6;
    localparam logic [3:0] SEL_SLT  = 4'd7;
    localparam logic [3:0] SEL_SLTU = 4'd8;
    localparam logic [3:0] SEL_NOR  = 4'd12;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             dz_pend_q, dz_pend_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             zf_q, zf_d, nf_q, nf_d, cf_q, cf_d, ovf_q, ovf_d, dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf, alu_ovf;

    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] step_hi, step_lo;

    always_comb begin
        add_full = {1'b0, OP1} + {1'b0, OP2};
        sub_full = {1'b0, OP1} - {1'b0, OP2};
        alu_res  = '0;
        alu_cf   = 1'b0;
        alu_ovf  = 1'b0;
        case (Sel)
            SEL_AND:  alu_res = OP1 & OP2;
            SEL_OR:   alu_res = OP1 | OP2;
            SEL_XOR:  alu_res = OP1 ^ OP2;
            SEL_NOR:  alu_res = ~(OP1 | OP2);
            SEL_ADD: begin
                alu_res = add_full[WIDTH-1:0];
                alu_cf  = add_full[WIDTH];
                alu_ovf = (OP1[WIDTH-1] == OP2[WIDTH-1]) &&
                          (add_full[WIDTH-1] != OP1[WIDTH-1]);
            end
            SEL_SUB: begin
                alu_res = sub_full[WIDTH-1:0];
                alu_cf  = sub_full[WIDTH];
                alu_ovf = (OP1[WIDTH-1] != OP2[WIDTH-1]) &&
                          (sub_full[WIDTH-1] != OP1[WIDTH-1]);
            end
            SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
            SEL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (OP1 < OP2)};
            default:  alu_res = '0;
        endcase
    end

    // hi_q/lo_q hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        if (is_div_q) begin
            step_hi = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
        end else begin
            {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        dz_pend_d = dz_pend_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        res_d     = res_q;
        res_hi_d  = res_hi_q;
        zf_d      = zf_q;
        nf_d      = nf_q;
        cf_d      = cf_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Sel == SEL_MUL || Sel == SEL_DIV) begin
                        state_d   = RUN;
                        cnt_d     = CW'(WIDTH);
                        is_div_d  = (Sel == SEL_DIV);
                        dz_pend_d = (Sel == SEL_DIV) && (OP2 == '0);
                        opb_d     = OP2;
                        hi_d      = '0;
                        lo_d      = OP1;
                    end else begin
                        res_d    = alu_res;
                        res_hi_d = '0;
                        zf_d     = (alu_res == '0);
                        nf_d     = alu_res[WIDTH-1];
                        cf_d     = alu_cf;
                        ovf_d    = alu_ovf;
                        dz_d     = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CW'(1);
                // Divide-by-zero needs no special path: restoring division by 0
                // naturally yields all-ones quotient and remainder = dividend.
                if (cnt_q == CW'(1)) begin
                    state_d  = IDLE;
                    res_d    = step_lo;
                    res_hi_d = step_hi;
                    zf_d     = (step_lo == '0);
                    nf_d     = step_lo[WIDTH-1];
                    cf_d     = 1'b0;
                    ovf_d    = 1'b0;
                    dz_d     = dz_pend_q;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            dz_pend_q <= 1'b0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_q     <= '0;
            res_hi_q  <= '0;
            zf_q      <= 1'b0;
            nf_q      <= 1'b0;
            cf_q      <= 1'b0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            dz_pend_q <= dz_pend_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            res_q     <= res_d;
            res_hi_q  <= res_hi_d;
            zf_q      <= zf_d;
            nf_q      <= nf_d;
            cf_q      <= cf_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign Busy        = (state_q == RUN);
    assign Done        = done_q;
    assign Resultado   = res_q;
    assign ResultadoHi = res_hi_q;
    assign ZF          = zf_q;
    assign NF          = nf_q;
    assign CF          = cf_q;
    assign OVF         = ovf_q;
    assign DZ          = dz_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo: vector table for every opcode plus hand-written
// sequences for back-to-back start, ignored start while busy and reset mid-operation.
module tb_alu_multiciclo;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         Start;
    logic [3:0]   Sel;
    logic [W-1:0] OP1, OP2;
    logic         Busy, Done, ZF, NF, CF, OVF, DZ;
    logic [W-1:0] Resultado, ResultadoHi;

    int checks = 0;
    int errors = 0;

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Sel(Sel), .OP1(OP1), .OP2(OP2),
        .Busy(Busy), .Done(Done), .Resultado(Resultado), .ResultadoHi(ResultadoHi),
        .ZF(ZF), .NF(NF), .CF(CF), .OVF(OVF), .DZ(DZ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [4:0]   fl;   // {ZF,NF,CF,OVF,DZ}
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        int busy_cnt;
        bit multi;
        multi = (v.sel == 4'd3) || (v.sel == 4'd4);
        lat = 0;
        busy_cnt = 0;
        @(negedge clk);
        Start = 1'b1; Sel = v.sel; OP1 = v.a; OP2 = v.b;
        @(posedge clk);
        #1;
        Start = 1'b0; Sel = 4'($urandom_range(0, 15)); OP1 = $urandom; OP2 = $urandom;
        do begin
            @(negedge clk);
            lat++;
            if (!Done && Busy) busy_cnt++;
        end while (!Done && lat < 100);
        chk({tag, " latency"}, 64'(lat), multi ? 64'(W + 1) : 64'd1);
        chk({tag, " busy cycles"}, 64'(busy_cnt), multi ? 64'(W) : 64'd0);
        chk({tag, " busy at done"}, 64'(Busy), 64'd0);
        chk({tag, " Resultado"}, 64'(Resultado), 64'(v.res));
        chk({tag, " ResultadoHi"}, 64'(ResultadoHi), 64'(v.hi));
        chk({tag, " flags"}, 64'({ZF, NF, CF, OVF, DZ}), 64'(v.fl));
        @(negedge clk);
        chk({tag, " hold"}, {27'd0, Done, Resultado, ZF, NF, CF, OVF, DZ},
            {27'd0, 1'b0, v.res, v.fl});
    endtask

    initial begin
        int cyc;
        int done_cnt;
        //          sel    a             b             res           hi            ZNCOD
        vecs[0]  = '{4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        5'b01010};
        vecs[1]  = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        5'b10100};
        vecs[2]  = '{4'd6,  32'd5,        32'd5,        32'h00000000, 32'h0,        5'b10000};
        vecs[3]  = '{4'd6,  32'd3,        32'd5,        32'hFFFFFFFE, 32'h0,        5'b01100};
        vecs[4]  = '{4'd6,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        5'b00010};
        vecs[5]  = '{4'd0,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,        5'b01000};
        vecs[6]  = '{4'd1,  32'h12340000, 32'h00005678, 32'h12345678, 32'h0,        5'b00000};
        vecs[7]  = '{4'd5,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 32'h0,        5'b10000};
        vecs[8]  = '{4'd12, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0,        5'b01000};
        vecs[9]  = '{4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        5'b00000};
        vecs[10] = '{4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        5'b10000};
        vecs[11] = '{4'd9,  32'd5,        32'd5,        32'h00000000, 32'h0,        5'b10000};
        vecs[12] = '{4'd3,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 5'b01000};
        vecs[13] = '{4'd3,  32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 5'b10000};
        vecs[14] = '{4'd3,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 5'b00000};
        vecs[15] = '{4'd4,  32'd100,      32'd7,        32'd14,       32'd2,        5'b00000};
        vecs[16] = '{4'd4,  32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        5'b01001};
        vecs[17] = '{4'd4,  32'd5,        32'd10,       32'h00000000, 32'd5,        5'b10000};
        vecs[18] = '{4'd15, 32'h12345678, 32'h1,        32'h00000000, 32'h0,        5'b10000};
        vecs[19] = '{4'd4,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        5'b01000};

        rst_n = 1'b0; Start = 1'b0; Sel = 4'd0; OP1 = '0; OP2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {27'd0, Busy, Done, Resultado, ZF, NF, CF, OVF, DZ}, 64'd0);
        chk("reset hi", 64'(ResultadoHi), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // back-to-back: DIV then ADD issued in the Done cycle
        @(negedge clk);
        Start = 1'b1; Sel = 4'd4; OP1 = 32'd100; OP2 = 32'd7;
        @(posedge clk);
        #1 Start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!Done && cyc < 100);
        chk("b2b div latency", 64'(cyc), 64'(W + 1));
        Start = 1'b1; Sel = 4'd2; OP1 = 32'd10; OP2 = 32'd20;
        @(posedge clk);
        #1 Start = 1'b0;
        @(negedge clk);
        chk("b2b add done", 64'(Done), 64'd1);
        chk("b2b add result", 64'({ResultadoHi, Resultado}), {32'd0, 32'd30});

        // MUL, ignored ADD start while busy, then reset mid-run
        @(negedge clk);
        Start = 1'b1; Sel = 4'd3; OP1 = 32'hFFFFFFFF; OP2 = 32'd2;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (4) @(negedge clk);
        Start = 1'b1; Sel = 4'd2; OP1 = 32'd1; OP2 = 32'd1;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        chk("busy start ignored", {62'd0, Busy, Done}, 64'd2);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-run reset outputs", {27'd0, Busy, Done, Resultado, ZF, NF, CF, OVF, DZ}, 64'd0);
        chk("mid-run reset hi", 64'(ResultadoHi), 64'd0);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (Done) done_cnt++;
        end
        chk("no done after abort", 64'(done_cnt), 64'd0);
        run_vec('{4'd2, 32'd2, 32'd3, 32'd5, 32'd0, 5'b00000}, "post-reset add");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
